// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port result RAM between locked write-back bursts and single-word reads,
// alternating round-robin between complete transactions.
module ram_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter int BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_req,
  input  logic [AW-1:0]              wb_base,
  input  logic [DW-1:0]              wb_data,
  output logic                       wb_gnt,
  output logic [$clog2(BURST)-1:0]   wb_beat,
  output logic                       wb_done,
  input  logic                       rd_req,
  input  logic [AW-1:0]              rd_addr,
  output logic                       rd_gnt,
  output logic                       rd_valid,
  output logic [DW-1:0]              rd_data,
  output logic                       ram_csn,
  output logic                       ram_wen,
  output logic [AW-1:0]              ram_addr,
  output logic [DW-1:0]              ram_wdata,
  input  logic [DW-1:0]              ram_rdata
);
  localparam int BW = $clog2(BURST);
  localparam logic [BW-1:0] LAST = BW'(BURST - 1);
  typedef enum logic {IDLE, WB} state_t;
  state_t r_state, w_next;
  logic [BW-1:0] r_beat;
  logic [AW-1:0] r_base;
  logic r_last_wb, r_rd_valid, w_wb_win, w_rd_win, w_burst;
  // Grants are gated by rst so a request held through reset never reaches the RAM.
  always_comb begin
    w_burst = r_state == WB;
    w_wb_win = rst && !w_burst && wb_req && (!rd_req || !r_last_wb);
    w_rd_win = rst && !w_burst && rd_req && !w_wb_win;
    wb_done = w_burst && r_beat == LAST;
    wb_gnt = w_wb_win || w_burst;
    rd_gnt = w_rd_win;
    w_next = wb_done ? IDLE : w_wb_win ? WB : r_state;
    ram_csn = !(wb_gnt || rd_gnt);
    ram_wen = !wb_gnt;
    ram_addr = w_burst ? r_base + AW'(r_beat) : w_wb_win ? wb_base : w_rd_win ? rd_addr : '0;
    ram_wdata = wb_gnt ? wb_data : '0;
  end
  assign wb_beat = r_beat;
  assign rd_valid = r_rd_valid;
  assign rd_data = ram_rdata;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_beat <= '0;
      r_base <= '0;
      r_last_wb <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rd_valid <= w_rd_win;
      r_beat <= wb_done ? '0 : w_wb_win ? BW'(1) : w_burst ? r_beat + 1'b1 : r_beat;
      if (w_wb_win) r_base <= wb_base;
      r_last_wb <= wb_done ? 1'b1 : w_rd_win ? 1'b0 : r_last_wb;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed traffic against a transaction-level model with a queued scoreboard.
module tb_ram_arbiter;
  localparam int AW = 8, DW = 32, BURST = 4;
  logic clk = 0, rst = 0;
  logic wb_req = 0, rd_req = 0, wb_gnt, wb_done, rd_gnt, rd_valid, ram_csn, ram_wen;
  logic [AW-1:0] wb_base = 0, rd_addr = 0, ram_addr;
  logic [DW-1:0] wb_data = 0, rd_data, ram_wdata, ram_rdata = 0;
  logic [$clog2(BURST)-1:0] wb_beat;
  ram_arbiter #(.AW(AW), .DW(DW), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .wb_req(wb_req), .wb_base(wb_base), .wb_data(wb_data),
    .wb_gnt(wb_gnt), .wb_beat(wb_beat), .wb_done(wb_done), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data), .ram_csn(ram_csn), .ram_wen(ram_wen),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  always #5 clk = ~clk;
  int cyc = 0, n_chk = 0, n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // RAM model with a bench-side preload port
  logic [DW-1:0] mem [256];
  logic pre_we = 0;
  logic [AW-1:0] pre_a = 0;
  logic [DW-1:0] pre_d = 0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (!ram_csn) begin
      if (!ram_wen) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end
  typedef struct { int c; logic [AW-1:0] a; logic [DW-1:0] d; int b; bit dn; } wexp_t;
  typedef struct { int c; logic [DW-1:0] d; } rexp_t;
  typedef struct { int c; logic [AW-1:0] a; } gexp_t;
  wexp_t wq[$];
  rexp_t rq[$];
  gexp_t gq[$];
  wexp_t we;
  rexp_t re;
  gexp_t ge;
  logic [DW-1:0] ref_mem [256];
  bit m_busy = 0, m_last_wb = 0;
  int m_beat = 0;
  logic [AW-1:0] m_base = 0;
  bit wb_want = 0, rd_want = 0, fix_data = 0, drop_mode = 0;
  logic [AW-1:0] wb_base_v = 0, rd_addr_v = 0;
  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic push_w(input logic [AW-1:0] a, input logic [DW-1:0] d, input int b);
    wq.push_back('{cyc, a, d, b, b == BURST - 1});
    ref_mem[a] = d;
  endtask
  // Requesters drive this cycle's inputs; the model decides who owns the RAM from the arbitration rules.
  task automatic drive_and_model();
    wb_req = m_busy ? (drop_mode ? 1'($urandom_range(0, 1)) : 1'b1) : wb_want;
    wb_base = m_busy ? 8'($urandom) : wb_base_v;
    wb_data = fix_data ? 32'hA0 + 32'(m_beat) : $urandom;
    rd_req = rd_want;
    rd_addr = rd_addr_v;
    if (m_busy) begin
      push_w(m_base + 8'(m_beat), wb_data, m_beat);
      m_beat++;
      if (m_beat == BURST) begin
        m_busy = 0; m_beat = 0; m_last_wb = 1; wb_want = 0;
      end
    end else if (wb_req && (!rd_req || !m_last_wb)) begin
      push_w(wb_base, wb_data, 0);
      m_base = wb_base; m_busy = 1; m_beat = 1;
    end else if (rd_req) begin
      gq.push_back('{cyc, rd_addr});
      rq.push_back('{cyc + 1, ref_mem[rd_addr]});
      m_last_wb = 0; rd_want = 0;
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
      drive_and_model();
    end
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 0; wb_req = 1; rd_req = 1;
    m_busy = 0; m_beat = 0; m_last_wb = 0; wb_want = 0; rd_want = 0;
    wq.delete(); rq.delete(); gq.delete();
    repeat (2) begin
      @(negedge clk);
      chk(wb_gnt == 0, "rst_wb_gnt", wb_gnt, 0);
      chk(rd_gnt == 0, "rst_rd_gnt", rd_gnt, 0);
      chk(wb_done == 0, "rst_wb_done", wb_done, 0);
      chk(ram_csn == 1, "rst_csn", ram_csn, 1);
      chk(ram_wen == 1, "rst_wen", ram_wen, 1);
      chk(ram_addr == 0, "rst_addr", ram_addr, 0);
      chk(ram_wdata == 0, "rst_wdata", ram_wdata, 0);
      chk(rd_valid == 0, "rst_rd_valid", rd_valid, 0);
      chk(wb_beat == 0, "rst_beat", wb_beat, 0);
    end
    @(posedge clk); #1;
    rst = 1;
    drive_and_model();
  endtask
  // Monitor: pops expectations whenever the DUT shows a write beat, a read grant or read data.
  always @(negedge clk) if (rst) begin
    while (wq.size() > 0 && wq[0].c < cyc) begin chk(wq[0].c == cyc, "wb_missing_cycle", cyc, wq[0].c); wq.delete(0); end
    while (gq.size() > 0 && gq[0].c < cyc) begin chk(gq[0].c == cyc, "rd_gnt_missing_cycle", cyc, gq[0].c); gq.delete(0); end
    while (rq.size() > 0 && rq[0].c < cyc) begin chk(rq[0].c == cyc, "rd_valid_missing_cycle", cyc, rq[0].c); rq.delete(0); end
    chk(!(wb_gnt && rd_gnt), "both_gnt", {wb_gnt, rd_gnt}, 2'b00);
    chk(ram_wen || wb_gnt, "wen_without_wb", ram_wen, 1);
    chk(!wb_done || wb_gnt, "done_without_gnt", wb_done, 0);
    if (wb_gnt) begin
      chk(wq.size() > 0, "wb_unexpected", cyc, 0);
      if (wq.size() > 0) begin
        we = wq.pop_front();
        chk(we.c == cyc, "wb_cycle", cyc, we.c);
        chk(ram_addr == we.a, "wb_addr", ram_addr, we.a);
        chk(ram_wdata == we.d, "wb_wdata", ram_wdata, we.d);
        chk(int'(wb_beat) == we.b, "wb_beat", wb_beat, we.b);
        chk(wb_done == we.dn, "wb_done", wb_done, we.dn);
        chk(!ram_csn && !ram_wen, "wb_strobes", {ram_csn, ram_wen}, 2'b00);
      end
    end
    if (rd_gnt) begin
      chk(gq.size() > 0, "rd_gnt_unexpected", cyc, 0);
      if (gq.size() > 0) begin
        ge = gq.pop_front();
        chk(ge.c == cyc, "rd_gnt_cycle", cyc, ge.c);
        chk(ram_addr == ge.a, "rd_addr", ram_addr, ge.a);
        chk(!ram_csn && ram_wen, "rd_strobes", {ram_csn, ram_wen}, 2'b01);
      end
    end
    if (!wb_gnt && !rd_gnt)
      chk(ram_csn && ram_wen && ram_addr == 0 && ram_wdata == 0 && wb_beat == 0 && !wb_done, "idle_bus",
          {ram_csn, ram_wen, ram_addr, wb_beat, wb_done}, {1'b1, 1'b1, 8'h00, 2'b00, 1'b0});
    if (rd_valid) begin
      chk(rq.size() > 0, "rd_valid_unexpected", cyc, 0);
      if (rq.size() > 0) begin
        re = rq.pop_front();
        chk(re.c == cyc, "rd_valid_cycle", cyc, re.c);
        chk(rd_data == re.d, "rd_data", rd_data, re.d);
      end
    end
  end
  initial begin
    pre_we = 1;
    for (int a = 0; a < 256; a++) begin
      pre_a = 8'(a);
      pre_d = a == 5 ? 32'h1234_5678 : $urandom;
      ref_mem[a] = pre_d;
      @(posedge clk); #1;
    end
    pre_we = 0;
    do_reset();
    // single burst with beat-dependent data
    fix_data = 1; wb_want = 1; wb_base_v = 8'h10;
    step(6);
    fix_data = 0;
    // read latency then three back-to-back reads
    rd_want = 1; rd_addr_v = 8'h05;
    step(2);
    for (int k = 0; k < 3; k++) begin rd_want = 1; rd_addr_v = 8'(k + 5); step(); end
    step(2);
    // continuous contention from reset
    do_reset();
    for (int k = 0; k < 16; k++) begin wb_want = 1; wb_base_v = 8'(8'h30 + k); rd_want = 1; rd_addr_v = 8'(8'h30 + k); step(); end
    wb_want = 0; rd_want = 0;
    step(6);
    // read raised during beat 1 is held off until after wb_done
    wb_want = 1; wb_base_v = 8'h20;
    step();
    rd_want = 1; rd_addr_v = 8'h21;
    step(6);
    // address wrap
    wb_want = 1; wb_base_v = 8'hFE;
    step(6);
    // reset during beat 2, then a tie must go to wb
    wb_want = 1; wb_base_v = 8'h40;
    step(2);
    do_reset();
    step(2);
    wb_want = 1; wb_base_v = 8'h50; rd_want = 1; rd_addr_v = 8'h40;
    step(7);
    // randomized traffic
    drop_mode = 1;
    for (int k = 0; k < 2000; k++) begin
      if (!m_busy && !wb_want && $urandom_range(0, 3) == 0) begin wb_want = 1; wb_base_v = 8'($urandom); end
      if (!rd_want && $urandom_range(0, 2) == 0) begin rd_want = 1; rd_addr_v = 8'($urandom); end
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end
    wb_want = 0; rd_want = 0;
    step(8);
    chk(wq.size() == 0, "wb_leftover", wq.size(), 0);
    chk(gq.size() == 0, "rd_gnt_leftover", gq.size(), 0);
    chk(rq.size() == 0, "rd_valid_leftover", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Owns the single-port 256x32 result RAM and shares it between two requesters.
- Write-back path: issues fixed-length write bursts of BURST words, such as the four MU results of one step.
- Readout path: issues single-word reads.
- Write bursts are locked (never interrupted). Arbitration between complete transactions is round-robin, so neither side starves.

Parameters:
AW, 8, RAM address width
DW, 32, RAM data width
BURST, 4, words per write-back burst (2..16); beat counter width is clog2(BURST)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
wb_req  input  1  write-back burst request; level, held until wb_done
wb_base  input  AW  burst base address; sampled on the first beat
wb_data  input  DW  write data for the beat indexed by wb_beat
wb_gnt  output  1  high in every cycle a wb beat is written
wb_beat  output  clog2(BURST)  index of the current beat; 0 when not bursting
wb_done  output  1  one-cycle pulse on the final beat
rd_req  input  1  read request; level, held until rd_gnt
rd_addr  input  AW  read address
rd_gnt  output  1  read accepted this cycle
rd_valid  output  1  read data valid
rd_data  output  DW  read data (ram_rdata passthrough)
ram_csn  output  1  RAM chip select, active-low
ram_wen  output  1  RAM write enable, active-low
ram_addr  output  AW  RAM address
ram_wdata  output  DW  RAM write data
ram_rdata  input  DW  RAM read data; synchronous, valid one cycle after the address

Behaviour:
- State machine: IDLE, WB.
- Registers:
  - state
  - beat counter
  - latched base address
  - last_owner (WB/RD)
  - rd_valid flop
- Reset (rst low, asynchronous):
  - state=IDLE, beat=0, base=0, last_owner=RD (so wb wins the first tie), rd_valid=0.
  - Combinational outputs then settle to wb_gnt=0, rd_gnt=0, wb_done=0, ram_csn=1, ram_wen=1, ram_addr=0, ram_wdata=0.
- IDLE arbitration, combinational in the same cycle:
  - Only wb_req: wb wins.
  - Only rd_req: rd wins.
  - Both: the requester that is not last_owner wins.
  - Neither: ram_csn=1, ram_addr=0, ram_wdata=0.
- wb wins in cycle T:
  - Beat 0 is written in T: wb_gnt=1, ram_csn=0, ram_wen=0, ram_addr=wb_base, ram_wdata=wb_data.
  - wb_base is latched; state goes to WB with beat=1.
- WB state, beat k (1..BURST-1):
  - wb_gnt=1, ram_csn=0, ram_wen=0.
  - ram_addr=(base+k) mod 2^AW (wraps, no carry out); ram_wdata=wb_data.
  - On k=BURST-1: wb_done=1; next state IDLE, beat=0, last_owner=WB.
- Burst length and locking:
  - A burst always spans exactly BURST consecutive cycles T..T+BURST-1.
  - wb_req is ignored after beat 0; deasserting it mid-burst does not abort.
  - rd_req is held off (rd_gnt=0) for the whole burst.
- rd wins in IDLE:
  - rd_gnt=1, ram_csn=0, ram_wen=1, ram_addr=rd_addr; last_owner=RD; state stays IDLE.
  - rd_valid=1 next cycle, with rd_data=ram_rdata. Read latency is 1 cycle after rd_gnt.
- Throughput:
  - Back-to-back reads: one per cycle when wb is idle.
  - With both requesting continuously, the schedule alternates one full burst, one read, one burst, and so on.
  - wb may start a new burst in the cycle right after wb_done if rd_req is low.
- rd_data when rd_valid=0: don't-care (passthrough); the bench checks it only under rd_valid.
- Reset mid-burst: the remaining beats are abandoned, no further writes occur, and the state returns to IDLE. The requester must re-request after reset.
- At most one of wb_gnt/rd_gnt is high in any cycle. ram_wen=0 only when wb_gnt=1.

Test Plan:
1. Single burst: wb_req=1, wb_base=8'h10, wb_data=beat-dependent 32'hA0+beat -> writes 10..13 over 4 consecutive cycles with data A0..A3; wb_done on the 4th cycle only; ram_csn=1 afterwards.
2. Read latency: preload addr 8'h05=32'h1234_5678; rd_req=1, rd_addr=8'h05 -> rd_gnt in cycle T, rd_valid=1 and rd_data=32'h1234_5678 in T+1; 3 reads held back-to-back produce 3 consecutive rd_valid cycles.
3. Contention from reset: wb_req and rd_req both high continuously -> wb burst (4 cycles), then read (1 cycle), then wb burst; rd_gnt is never high during wb_gnt.
4. Read during burst: rd_req rises on beat 1 -> rd_gnt held 0 through beat 3, rd_gnt=1 in the cycle after wb_done.
5. Address wrap: wb_base=8'hFE -> addresses FE, FF, 00, 01.
6. Reset mid-burst: assert rst low during beat 2 -> immediately ram_csn=1, ram_wen=1, wb_gnt=0; after release no writes occur until a new wb_req; the next contention tie goes to wb.
